// File: rtl/pti_seq_pkg.sv
// Shared definitions for the PTI DDR trace sequencer.
// Holds the sequencer state encoding, the per-lane DDR bit-pair patterns
// driven in each state, and helpers that derive beat geometry from the
// lane count.
package pti_seq_pkg;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    TRAIN    = 2'd1,
    IDLE     = 2'd2,
    DATA     = 2'd3
  } seqState_e;

  // DDR bit pairs: bit 0 goes out first, bit 1 second.
  localparam logic [1:0] TRAIN_PAT = 2'b01;
  localparam logic [1:0] CLK_PAT   = 2'b10;
  localparam logic [1:0] IDLE_PAT  = 2'b00;
  localparam logic [1:0] OFF_PAT   = 2'b00;

  // A 16-bit word is carried as 8 bit-pairs spread across the lanes.
  function automatic int beatsFor(input int lanes);
    return 8 / lanes;
  endfunction

  // Beat counter width; kept at least 1 bit so LANES=8 still has a signal.
  function automatic int beatWidth(input int lanes);
    return (lanes >= 8) ? 1 : $clog2(8 / lanes);
  endfunction

endpackage

// File: rtl/pti_beat_shifter.sv
// Word holder and beat selector for the PTI DDR sequencer.
// Captures the accepted trace word and returns the lane slice for a given
// beat. The slice is computed from the word as it will be after this clock
// edge, so the parent can register it and show beat 0 one cycle after the
// handshake.
// Ports:
//   iClk, iReset : clock, synchronous active-high reset
//   iLoad        : capture iWord at this edge
//   iWord        : incoming 16-bit trace word
//   iBeat        : beat index to select (the beat for the next cycle)
//   oSlice       : 2*LANES bits of the selected beat
module pti_beat_shifter
  import pti_seq_pkg::*;
#(
  parameter  int LANES   = 4,
  localparam int BEAT_W  = beatWidth(LANES),
  localparam int SLICE_W = 2 * LANES
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iLoad,
  input  logic [15:0]        iWord,
  input  logic [BEAT_W-1:0]  iBeat,
  output logic [SLICE_W-1:0] oSlice
);

  logic [15:0] wordQ;
  logic [15:0] wordNext;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      wordQ <= '0;
    end else if (iLoad) begin
      wordQ <= iWord;
    end
  end

  // Bypass on load so beat 0 of a new word is available at the load edge.
  assign wordNext = iLoad ? iWord : wordQ;
  assign oSlice   = wordNext[int'(iBeat) * SLICE_W +: SLICE_W];

endmodule

// File: rtl/pti_ddr_sequencer.sv
// PTI DDR trace output sequencer.
// Serialises 16-bit trace words onto LANES DDR data lanes plus a DDR clock
// lane, with a training preamble after every enable. The DDR output cells
// themselves live in the parent; this block only produces the bit pairs.
// Ports:
//   iClk       : clock, also TX_CLK of the downstream DDR cells
//   iReset     : synchronous active-high reset
//   iEnable    : trace output enable
//   iData      : trace word, accepted when iValid && oReady
//   iValid     : iData is valid
//   oReady     : block accepts iData this cycle
//   oLaneData  : DDR bit pair per lane, lane l at [2l+1:2l], bit 2l first
//   oClkData   : DDR bit pair for the PTI clock lane
//   oTraining  : high while training
//   oUnderflow : sticky, stream went idle after back-to-back words
//
// state    | meaning
// DISABLED | outputs parked at zero, clock lane stopped
// TRAIN    | all lanes drive 01 for TRAIN_CYCLES cycles
// IDLE     | clock running, lanes zero, waiting for a word
// DATA     | shifting out beats of the held word
module pti_ddr_sequencer
  import pti_seq_pkg::*;
#(
  parameter int LANES        = 4,
  parameter int TRAIN_CYCLES = 16
) (
  input  logic               iClk,
  input  logic               iReset,
  input  logic               iEnable,
  input  logic [15:0]        iData,
  input  logic               iValid,
  output logic               oReady,
  output logic [2*LANES-1:0] oLaneData,
  output logic [1:0]         oClkData,
  output logic               oTraining,
  output logic               oUnderflow
);

  localparam int BEATS  = beatsFor(LANES);
  localparam int BEAT_W = beatWidth(LANES);
  localparam int LW     = 2 * LANES;
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
  localparam logic [7:0]        TRAIN_LOAD = 8'(TRAIN_CYCLES - 1);

  seqState_e         state, stateNext;
  logic [BEAT_W-1:0] beat, beatNext;
  logic [7:0]        trainCnt, trainCntNext;
  logic              backToBack, backToBackNext;
  logic              underflowNext;
  logic              lastBeat;
  logic              handshake;
  logic              load;
  logic [LW-1:0]     slice;
  logic [LW-1:0]     laneNext;
  logic [1:0]        clkNext;

  assign lastBeat  = (beat == LAST_BEAT);
  assign oReady    = !iReset && iEnable &&
                     ((state == IDLE) || ((state == DATA) && lastBeat));
  assign handshake = iValid && oReady;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state      <= DISABLED;
      beat       <= '0;
      trainCnt   <= '0;
      backToBack <= 1'b0;
      oUnderflow <= 1'b0;
      oLaneData  <= '0;
      oClkData   <= OFF_PAT;
      oTraining  <= 1'b0;
    end else begin
      state      <= stateNext;
      beat       <= beatNext;
      trainCnt   <= trainCntNext;
      backToBack <= backToBackNext;
      oUnderflow <= underflowNext;
      oLaneData  <= laneNext;
      oClkData   <= clkNext;
      oTraining  <= (stateNext == TRAIN);
    end
  end

  always_comb begin
    stateNext      = state;
    beatNext       = beat;
    trainCntNext   = trainCnt;
    backToBackNext = backToBack;
    underflowNext  = oUnderflow;
    load           = 1'b0;
    case (state)
      DISABLED: begin
        if (iEnable) begin
          stateNext    = TRAIN;
          trainCntNext = TRAIN_LOAD;
        end
      end
      TRAIN: begin
        if (!iEnable) begin
          stateNext    = DISABLED;
          trainCntNext = '0;
        end else if (trainCnt == '0) begin
          stateNext = IDLE;
        end else begin
          trainCntNext = trainCnt - 8'd1;
        end
      end
      IDLE: begin
        if (!iEnable) begin
          stateNext = DISABLED;
        end else if (handshake) begin
          stateNext      = DATA;
          beatNext       = '0;
          load           = 1'b1;
          backToBackNext = 1'b0;
        end
      end
      DATA: begin
        if (!lastBeat) begin
          beatNext = beat + BEAT_W'(1);
        end else if (handshake) begin
          beatNext       = '0;
          load           = 1'b1;
          backToBackNext = 1'b1;
        end else if (!iEnable) begin
          stateNext = DISABLED;
          beatNext  = '0;
        end else begin
          // Stream dried up while still enabled: only a fault if the
          // word just finished was itself chained onto the previous one.
          stateNext     = IDLE;
          beatNext      = '0;
          underflowNext = oUnderflow | backToBack;
        end
      end
      default: begin
        stateNext = DISABLED;
      end
    endcase
  end

  // Output values are decoded from the next state so they land in flops.
  always_comb begin
    laneNext = {LANES{IDLE_PAT}};
    clkNext  = OFF_PAT;
    case (stateNext)
      TRAIN: begin
        laneNext = {LANES{TRAIN_PAT}};
        clkNext  = CLK_PAT;
      end
      IDLE: begin
        clkNext = CLK_PAT;
      end
      DATA: begin
        laneNext = slice;
        clkNext  = CLK_PAT;
      end
      default: begin
        laneNext = {LANES{IDLE_PAT}};
        clkNext  = OFF_PAT;
      end
    endcase
  end

  pti_beat_shifter #(
    .LANES(LANES)
  ) uShifter (
    .iClk  (iClk),
    .iReset(iReset),
    .iLoad (load),
    .iWord (iData),
    .iBeat (beatNext),
    .oSlice(slice)
  );

endmodule
